// File: rtl/nbit_serial_sub.sv
// Bit-serial N-bit subtractor: Diff = A - B - Bin, one full-subtractor step per clock, LSB first.
// Optional signed-overflow output is built when NBIT_SERIAL_SUB_OVF_EN is defined.
//
// state   | meaning
// S_IDLE  | waiting for start; operands are latched on an accepted start
// S_SHIFT | one operand bit processed per clock; busy=1
// S_DONE  | single cycle with done=1; then back to S_IDLE
module nbit_serial_sub #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         Bin,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] Diff,
   output logic         Bout
`ifdef NBIT_SERIAL_SUB_OVF_EN
   ,
   output logic         ovf
`endif
);

   localparam int CW = (N > 2) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t        state;
   logic [N-1:0]  a_sr;
   logic [N-1:0]  b_sr;
   logic          br;
   logic [CW-1:0] cnt;
   logic          d;
   logic          br_nxt;

   always_comb begin
      d      = a_sr[0] ^ b_sr[0] ^ br;
      br_nxt = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
   end

   // The minuend register doubles as the result register: each difference bit
   // enters at the MSB as the consumed operand bit leaves at the LSB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         a_sr  <= '0;
         b_sr  <= '0;
         br    <= 1'b0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         Diff  <= '0;
         Bout  <= 1'b0;
`ifdef NBIT_SERIAL_SUB_OVF_EN
         ovf   <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sr  <= A;
                  b_sr  <= B;
                  br    <= Bin;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               a_sr <= {d, a_sr[N-1:1]};
               b_sr <= {1'b0, b_sr[N-1:1]};
               br   <= br_nxt;
               cnt  <= cnt + CW'(1);
               if (cnt == LAST) begin
                  Diff  <= {d, a_sr[N-1:1]};
                  Bout  <= br_nxt;
`ifdef NBIT_SERIAL_SUB_OVF_EN
                  // on the last step the operand bits in hand are the latched MSBs
                  ovf   <= (a_sr[0] != b_sr[0]) && (d != a_sr[0]);
`endif
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nbit_serial_sub.sv
// Scoreboard bench for nbit_serial_sub (N=4); ovf is checked when NBIT_SERIAL_SUB_OVF_EN is defined.
module tb_nbit_serial_sub;

   localparam int N = 4;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         bin;
   logic         busy;
   logic         done;
   logic [N-1:0] diff;
   logic         bout;
`ifdef NBIT_SERIAL_SUB_OVF_EN
   logic         ovf;
`endif

   nbit_serial_sub #(.N(N)) dut (
`ifdef NBIT_SERIAL_SUB_OVF_EN
      .ovf   (ovf),
`endif
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (a),
      .B     (b),
      .Bin   (bin),
      .busy  (busy),
      .done  (done),
      .Diff  (diff),
      .Bout  (bout)
   );

   typedef struct packed {
      logic [N-1:0] diff;
      logic         bout;
      logic         ovf;
   } exp_t;

   exp_t sb[$];
   int   n_chk    = 0;
   int   n_pass   = 0;
   int   done_cnt = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   // output side of the scoreboard
   always @(posedge clk) begin
      #1;
      if (done === 1'b1) begin
         done_cnt++;
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("diff", {28'd0, diff}, {28'd0, e.diff});
            chk("bout", {31'd0, bout}, {31'd0, e.bout});
`ifdef NBIT_SERIAL_SUB_OVF_EN
            chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
`endif
         end
      end
   end

   function automatic exp_t model(input logic [N-1:0] ma, input logic [N-1:0] mb, input logic mbin);
      logic [N:0] full;
      exp_t       e;
      full   = {1'b0, ma} - {1'b0, mb} - {{N{1'b0}}, mbin};
      e.diff = full[N-1:0];
      e.bout = full[N];
      e.ovf  = (ma[N-1] != mb[N-1]) && (full[N-1] != ma[N-1]);
      return e;
   endfunction

   // hazard=1 re-drives A/B and pulses start while the operation is in flight
   task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tbin, input bit hazard);
      logic [N-1:0] prev_diff;
      logic         prev_bout;
      int           cycles;
      int           dc0;
      @(negedge clk);
      a = ta; b = tb; bin = tbin; start = 1'b1;
      sb.push_back(model(ta, tb, tbin));
      prev_diff = diff;
      prev_bout = bout;
      dc0 = done_cnt;
      @(posedge clk); #1;
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      @(negedge clk);
      start = 1'b0;
      a = ~ta; b = ~tb; bin = ~tbin;
      cycles = 1;
      if (hazard) begin
         @(posedge clk); #1;
         cycles = 2;
         @(negedge clk);
         a = 4'b1111; b = 4'b0001; start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         @(posedge clk); #1;
         cycles = 3;
      end else begin
         @(posedge clk); #1;
      end
      while (done !== 1'b1 && cycles < 20) begin
         chk("diff_held", {28'd0, diff}, {28'd0, prev_diff});
         chk("bout_held", {31'd0, bout}, {31'd0, prev_bout});
         chk("busy_shift", {31'd0, busy}, 32'd1);
         @(posedge clk); #1;
         cycles++;
      end
      chk("latency", cycles, N);
      chk("busy_at_done", {31'd0, busy}, 32'd0);
      @(posedge clk); #2;
      chk("done_one_cycle", {31'd0, done}, 32'd0);
      @(posedge clk); #2;
      chk("done_count", done_cnt - dc0, 32'd1);
      chk("idle_busy", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int dc0;
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
      #12;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_diff", {28'd0, diff}, 32'd0);
      chk("rst_bout", {31'd0, bout}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(4'b0011, 4'b0001, 1'b0, 1'b0);
      run_op(4'b0011, 4'b0100, 1'b1, 1'b0);
      run_op(4'b0000, 4'b0000, 1'b1, 1'b0);
      run_op(4'b1111, 4'b1111, 1'b0, 1'b0);
      run_op(4'b0101, 4'b0010, 1'b0, 1'b1);
      run_op(4'b0111, 4'b1111, 1'b0, 1'b0);
      run_op(4'b1000, 4'b0001, 1'b0, 1'b0);

      // abort mid-operation with an asynchronous reset
      run_op(4'b0101, 4'b0010, 1'b0, 1'b0);
      dc0 = done_cnt;
      @(negedge clk);
      a = 4'b1001; b = 4'b0011; bin = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("abort_diff", {28'd0, diff}, 32'd0);
      chk("abort_bout", {31'd0, bout}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("abort_no_done", done_cnt - dc0, 32'd0);

      run_op(4'b1001, 4'b0011, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
      end

      chk("sb_empty", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
